// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the decode stage: ALU operation codes, opcodes,
// immediate formats and the decoded-entry record held in the pipeline register.
package riscv_pkg;

   localparam logic [4:0] ALU_NONE  = 5'd0;
   localparam logic [4:0] ALU_ADD   = 5'd1;
   localparam logic [4:0] ALU_ADDI  = 5'd2;
   localparam logic [4:0] ALU_OR    = 5'd3;
   localparam logic [4:0] ALU_ORI   = 5'd4;
   localparam logic [4:0] ALU_XOR   = 5'd5;
   localparam logic [4:0] ALU_XORI  = 5'd6;
   localparam logic [4:0] ALU_AND   = 5'd7;
   localparam logic [4:0] ALU_ANDI  = 5'd8;
   localparam logic [4:0] ALU_SUB   = 5'd9;
   localparam logic [4:0] ALU_SLT   = 5'd10;
   localparam logic [4:0] ALU_SLTI  = 5'd11;
   localparam logic [4:0] ALU_SLTU  = 5'd12;
   localparam logic [4:0] ALU_SLTIU = 5'd13;
   localparam logic [4:0] ALU_SLLI  = 5'd14;
   localparam logic [4:0] ALU_SRLI  = 5'd15;
   localparam logic [4:0] ALU_SRAI  = 5'd16;
   localparam logic [4:0] ALU_SLL   = 5'd17;
   localparam logic [4:0] ALU_SRL   = 5'd18;
   localparam logic [4:0] ALU_SRA   = 5'd19;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5,
      IMM_SH   = 3'd6
   } imm_fmt_e;

   typedef struct packed {
      logic [4:0] alu_ctrl;
      logic       asel;
      logic       bsel;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [2:0] funct3;
      logic       branch;
      logic       jump;
      logic       illegal;
   } dec_t;

   // Drops every side-effecting control of an entry, leaving its data fields.
   function automatic dec_t clr_ctrl(input dec_t d);
      dec_t r;
      r           = d;
      r.reg_write = 1'b0;
      r.mem_read  = 1'b0;
      r.mem_write = 1'b0;
      r.branch    = 1'b0;
      r.jump      = 1'b0;
      r.illegal   = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational RV32I immediate generator: selects and sign-extends the
// immediate field of an instruction word according to its format.
import riscv_pkg::*;

module riscv_imm_gen (
   input  logic [31:0] instr_i,
   input  imm_fmt_e    fmt_i,
   output logic [31:0] imm_o
);

   // Format-directed immediate assembly; shift amounts never carry bit 30.
   always_comb begin
      imm_o = 32'h0000_0000;
      case (fmt_i)
         IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U:   imm_o = {instr_i[31:12], 12'h000};
         IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
         IMM_SH:  imm_o = {27'h000_0000, instr_i[24:20]};
         default: imm_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage with a one-entry valid/ready pipeline register and flush.
// Define RISCV_DEC_ILLEGAL_EN to report undecodable words on Illegal.
import riscv_pkg::*;

module riscv_decode_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        In_Valid,
   output logic        In_Ready,
   input  logic [31:0] Instr,
   input  logic [31:0] PC,
   input  logic        Flush,
   output logic        Out_Valid,
   input  logic        Out_Ready,
   output logic [4:0]  ALU_Ctrl,
   output logic        Asel,
   output logic        Bsel,
   output logic [31:0] Imm,
   output logic [31:0] PC_Out,
   output logic [4:0]  Rs1,
   output logic [4:0]  Rs2,
   output logic [4:0]  Rd,
   output logic        Reg_Write,
   output logic        Mem_Read,
   output logic        Mem_Write,
   output logic [2:0]  Funct3,
   output logic        Branch,
   output logic        Jump,
   output logic        Illegal
);

`ifdef RISCV_DEC_ILLEGAL_EN
   localparam logic ILLEGAL_EN = 1'b1;
`else
   localparam logic ILLEGAL_EN = 1'b0;
`endif

   logic [6:0]  opcode_s;
   logic [2:0]  funct3_s;
   logic [6:0]  funct7_s;
   logic        bad_s;
   logic        accept_s;
   imm_fmt_e    fmt_s;
   logic [31:0] imm_s;
   dec_t        dec_s;

   logic        valid_q, valid_d;
   dec_t        ent_q, ent_d;
   logic [31:0] imm_q, imm_d;
   logic [31:0] pc_q, pc_d;

   assign opcode_s = Instr[6:0];
   assign funct3_s = Instr[14:12];
   assign funct7_s = Instr[31:25];

   riscv_imm_gen u_imm_gen (
      .instr_i (Instr),
      .fmt_i   (fmt_s),
      .imm_o   (imm_s)
   );

   // Instruction cracking; undecodable words collapse to a NOP-like entry.
   always_comb begin
      dec_s        = '0;
      fmt_s        = IMM_NONE;
      bad_s        = 1'b0;
      dec_s.rs1    = Instr[19:15];
      dec_s.rs2    = Instr[24:20];
      dec_s.rd     = Instr[11:7];
      dec_s.funct3 = funct3_s;
      case (opcode_s)
         OPC_OP: begin
            dec_s.reg_write = 1'b1;
            if (funct7_s == F7_BASE) begin
               case (funct3_s)
                  3'd0:    dec_s.alu_ctrl = ALU_ADD;
                  3'd1:    dec_s.alu_ctrl = ALU_SLL;
                  3'd2:    dec_s.alu_ctrl = ALU_SLT;
                  3'd3:    dec_s.alu_ctrl = ALU_SLTU;
                  3'd4:    dec_s.alu_ctrl = ALU_XOR;
                  3'd5:    dec_s.alu_ctrl = ALU_SRL;
                  3'd6:    dec_s.alu_ctrl = ALU_OR;
                  3'd7:    dec_s.alu_ctrl = ALU_AND;
                  default: bad_s = 1'b1;
               endcase
            end else if (funct7_s == F7_ALT && funct3_s == 3'd0) begin
               dec_s.alu_ctrl = ALU_SUB;
            end else if (funct7_s == F7_ALT && funct3_s == 3'd5) begin
               dec_s.alu_ctrl = ALU_SRA;
            end else begin
               bad_s = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec_s.bsel      = 1'b1;
            dec_s.reg_write = 1'b1;
            fmt_s           = IMM_I;
            case (funct3_s)
               3'd0: dec_s.alu_ctrl = ALU_ADDI;
               3'd2: dec_s.alu_ctrl = ALU_SLTI;
               3'd3: dec_s.alu_ctrl = ALU_SLTIU;
               3'd4: dec_s.alu_ctrl = ALU_XORI;
               3'd6: dec_s.alu_ctrl = ALU_ORI;
               3'd7: dec_s.alu_ctrl = ALU_ANDI;
               3'd1: begin
                  fmt_s          = IMM_SH;
                  dec_s.alu_ctrl = ALU_SLLI;
                  bad_s          = (funct7_s != F7_BASE);
               end
               3'd5: begin
                  fmt_s          = IMM_SH;
                  dec_s.alu_ctrl = (funct7_s == F7_ALT) ? ALU_SRAI : ALU_SRLI;
                  bad_s          = (funct7_s != F7_BASE) && (funct7_s != F7_ALT);
               end
               default: bad_s = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec_s.alu_ctrl  = ALU_ADDI;
            dec_s.rs1       = 5'd0;
            dec_s.bsel      = 1'b1;
            dec_s.reg_write = 1'b1;
            fmt_s           = IMM_U;
         end
         OPC_AUIPC: begin
            dec_s.alu_ctrl  = ALU_ADD;
            dec_s.asel      = 1'b1;
            dec_s.bsel      = 1'b1;
            dec_s.reg_write = 1'b1;
            fmt_s           = IMM_U;
         end
         OPC_LOAD: begin
            dec_s.alu_ctrl  = ALU_ADDI;
            dec_s.bsel      = 1'b1;
            dec_s.mem_read  = 1'b1;
            dec_s.reg_write = 1'b1;
            fmt_s           = IMM_I;
            bad_s           = (funct3_s == 3'd3) || (funct3_s[2:1] == 2'b11);
         end
         OPC_STORE: begin
            dec_s.alu_ctrl  = ALU_ADDI;
            dec_s.bsel      = 1'b1;
            dec_s.mem_write = 1'b1;
            fmt_s           = IMM_S;
            bad_s           = (funct3_s > 3'd2);
         end
         OPC_BRANCH: begin
            dec_s.branch = 1'b1;
            fmt_s        = IMM_B;
            case (funct3_s)
               3'd0, 3'd1: dec_s.alu_ctrl = ALU_SUB;
               3'd4, 3'd5: dec_s.alu_ctrl = ALU_SLT;
               3'd6, 3'd7: dec_s.alu_ctrl = ALU_SLTU;
               default:    bad_s = 1'b1;
            endcase
         end
         OPC_JAL: begin
            dec_s.jump      = 1'b1;
            dec_s.alu_ctrl  = ALU_ADD;
            dec_s.asel      = 1'b1;
            dec_s.bsel      = 1'b1;
            dec_s.reg_write = 1'b1;
            fmt_s           = IMM_J;
         end
         OPC_JALR: begin
            dec_s.jump      = 1'b1;
            dec_s.alu_ctrl  = ALU_ADDI;
            dec_s.bsel      = 1'b1;
            dec_s.reg_write = 1'b1;
            fmt_s           = IMM_I;
         end
         default: bad_s = 1'b1;
      endcase
      // x0 is never written, whatever the instruction.
      if (dec_s.rd == 5'd0) begin
         dec_s.reg_write = 1'b0;
      end else begin
         dec_s.reg_write = dec_s.reg_write;
      end
      if (bad_s) begin
         dec_s          = clr_ctrl(dec_s);
         dec_s.alu_ctrl = ALU_NONE;
         dec_s.asel     = 1'b0;
         dec_s.bsel     = 1'b0;
         dec_s.illegal  = ILLEGAL_EN;
         fmt_s          = IMM_NONE;
      end else begin
         dec_s.illegal  = 1'b0;
      end
   end

   assign In_Ready = !valid_q || Out_Ready;
   assign accept_s = In_Valid && In_Ready;

   // Pipeline register next state: flush beats accept, accept beats drain.
   always_comb begin
      valid_d = valid_q;
      ent_d   = ent_q;
      imm_d   = imm_q;
      pc_d    = pc_q;
      if (Flush) begin
         valid_d = 1'b0;
         ent_d   = clr_ctrl(ent_q);
      end else if (accept_s) begin
         valid_d = 1'b1;
         ent_d   = dec_s;
         imm_d   = imm_s;
         pc_d    = PC;
      end else if (Out_Ready) begin
         valid_d = 1'b0;
         ent_d   = clr_ctrl(ent_q);
      end else begin
         valid_d = valid_q;
         ent_d   = ent_q;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         ent_q   <= '0;
         imm_q   <= 32'h0000_0000;
         pc_q    <= RESET_PC;
      end else begin
         valid_q <= valid_d;
         ent_q   <= ent_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
      end
   end

   assign Out_Valid = valid_q;
   assign ALU_Ctrl  = ent_q.alu_ctrl;
   assign Asel      = ent_q.asel;
   assign Bsel      = ent_q.bsel;
   assign Imm       = imm_q;
   assign PC_Out    = pc_q;
   assign Rs1       = ent_q.rs1;
   assign Rs2       = ent_q.rs2;
   assign Rd        = ent_q.rd;
   assign Reg_Write = ent_q.reg_write;
   assign Mem_Read  = ent_q.mem_read;
   assign Mem_Write = ent_q.mem_write;
   assign Funct3    = ent_q.funct3;
   assign Branch    = ent_q.branch;
   assign Jump      = ent_q.jump;
   assign Illegal   = ent_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Self-checking bench for riscv_decode_stage: hand-derived expected entries go
// through a scoreboard queue and are compared as the stage presents them.
module tb_riscv_decode_stage;

   logic        clk;
   logic        rst;
   logic        In_Valid;
   logic        In_Ready;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic        Flush;
   logic        Out_Valid;
   logic        Out_Ready;
   logic [4:0]  ALU_Ctrl;
   logic        Asel;
   logic        Bsel;
   logic [31:0] Imm;
   logic [31:0] PC_Out;
   logic [4:0]  Rs1;
   logic [4:0]  Rs2;
   logic [4:0]  Rd;
   logic        Reg_Write;
   logic        Mem_Read;
   logic        Mem_Write;
   logic [2:0]  Funct3;
   logic        Branch;
   logic        Jump;
   logic        Illegal;

`ifdef RISCV_DEC_ILLEGAL_EN
   localparam logic ILL_EXP = 1'b1;
`else
   localparam logic ILL_EXP = 1'b0;
`endif

   typedef struct packed {
      logic        valid;
      logic [4:0]  ctrl;
      logic        asel;
      logic        bsel;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [2:0]  f3;
      logic        br;
      logic        jmp;
      logic        ill;
   } obs_t;

   localparam int NVEC = 13;

   int          checks = 0;
   int          errors = 0;
   obs_t        sb_q[$];
   logic [31:0] vec_ins[NVEC];
   obs_t        vec_exp[NVEC];

   riscv_decode_stage dut (
      .clk       (clk),
      .rst       (rst),
      .In_Valid  (In_Valid),
      .In_Ready  (In_Ready),
      .Instr     (Instr),
      .PC        (PC),
      .Flush     (Flush),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .ALU_Ctrl  (ALU_Ctrl),
      .Asel      (Asel),
      .Bsel      (Bsel),
      .Imm       (Imm),
      .PC_Out    (PC_Out),
      .Rs1       (Rs1),
      .Rs2       (Rs2),
      .Rd        (Rd),
      .Reg_Write (Reg_Write),
      .Mem_Read  (Mem_Read),
      .Mem_Write (Mem_Write),
      .Funct3    (Funct3),
      .Branch    (Branch),
      .Jump      (Jump),
      .Illegal   (Illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t o;
      o.valid = Out_Valid; o.ctrl = ALU_Ctrl; o.asel = Asel; o.bsel = Bsel;
      o.imm = Imm; o.pc = PC_Out; o.rs1 = Rs1; o.rs2 = Rs2; o.rd = Rd;
      o.rw = Reg_Write; o.mr = Mem_Read; o.mw = Mem_Write; o.f3 = Funct3;
      o.br = Branch; o.jmp = Jump; o.ill = Illegal;
      return o;
   endfunction

   function automatic obs_t mk(input logic [31:0] ins, input logic [31:0] pc,
                               input logic [4:0] ctrl, input logic asel, input logic bsel,
                               input logic [31:0] imm, input logic [4:0] rs1,
                               input logic rw, input logic mr, input logic mw,
                               input logic br, input logic jmp);
      obs_t o;
      o.valid = 1'b1; o.ctrl = ctrl; o.asel = asel; o.bsel = bsel; o.imm = imm;
      o.pc = pc; o.rs1 = rs1; o.rs2 = ins[24:20]; o.rd = ins[11:7];
      o.rw = rw; o.mr = mr; o.mw = mw; o.f3 = ins[14:12];
      o.br = br; o.jmp = jmp; o.ill = 1'b0;
      return o;
   endfunction

   task automatic load_vectors();
      vec_ins[0]  = 32'hFFD08293; // addi x5,x1,-3
      vec_exp[0]  = mk(vec_ins[0], 32'h200, 5'd2, 1'b0, 1'b1, 32'hFFFFFFFD, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      vec_ins[1]  = 32'h4041D193; // srai x3,x3,4
      vec_exp[1]  = mk(vec_ins[1], 32'h204, 5'd16, 1'b0, 1'b1, 32'h4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      vec_ins[2]  = 32'h12345097; // auipc x1,0x12345
      vec_exp[2]  = mk(vec_ins[2], 32'h100, 5'd1, 1'b1, 1'b1, 32'h12345000, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      vec_ins[3]  = 32'hFE20ECE3; // bltu x1,x2,-8
      vec_exp[3]  = mk(vec_ins[3], 32'h108, 5'd12, 1'b0, 1'b0, 32'hFFFFFFF8, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      vec_ins[4]  = 32'hABCDE3B7; // lui x7,0xABCDE
      vec_exp[4]  = mk(vec_ins[4], 32'h10C, 5'd2, 1'b0, 1'b1, 32'hABCDE000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      vec_ins[5]  = 32'h00812303; // lw x6,8(x2)
      vec_exp[5]  = mk(vec_ins[5], 32'h110, 5'd2, 1'b0, 1'b1, 32'h8, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      vec_ins[6]  = 32'hFE512E23; // sw x5,-4(x2)
      vec_exp[6]  = mk(vec_ins[6], 32'h114, 5'd2, 1'b0, 1'b1, 32'hFFFFFFFC, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      vec_ins[7]  = 32'h001000EF; // jal x1,+2048
      vec_exp[7]  = mk(vec_ins[7], 32'h118, 5'd1, 1'b1, 1'b1, 32'h800, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      vec_ins[8]  = 32'h00008067; // jalr x0,0(x1)
      vec_exp[8]  = mk(vec_ins[8], 32'h11C, 5'd2, 1'b0, 1'b1, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      vec_ins[9]  = 32'h402081B3; // sub x3,x1,x2
      vec_exp[9]  = mk(vec_ins[9], 32'h120, 5'd9, 1'b0, 1'b0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      vec_ins[10] = 32'h01F21213; // slli x4,x4,31
      vec_exp[10] = mk(vec_ins[10], 32'h124, 5'd14, 1'b0, 1'b1, 32'h1F, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      vec_ins[11] = 32'h00000013; // addi x0,x0,0
      vec_exp[11] = mk(vec_ins[11], 32'h128, 5'd2, 1'b0, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vec_ins[12] = 32'h407352B3; // sra x5,x6,x7
      vec_exp[12] = mk(vec_ins[12], 32'h12C, 5'd19, 1'b0, 1'b0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      obs_t exp_o;
      rst = 1'b1; In_Valid = 1'b1; Instr = 32'hFFD08293; PC = 32'h40;
      Flush = 1'b0; Out_Ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      exp_o = '0;
      checks++;
      if (sample() !== exp_o) begin
         errors++;
         $display("FAIL reset_state got %h expected %h", sample(), exp_o);
      end
      rst = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
      checks++;
      if (In_Ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b expected 1", In_Ready);
      end
   endtask

   task automatic test_decode();
      obs_t exp_o;
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         In_Valid = 1'b1; Instr = vec_ins[i]; PC = vec_exp[i].pc; Out_Ready = 1'b1;
         sb_q.push_back(vec_exp[i]);
         @(negedge clk);
         In_Valid = 1'b0;
         checks++;
         if (!Out_Valid || sb_q.size() == 0) begin
            errors++;
            $display("FAIL decode_%0d no output valid=%b", i, Out_Valid);
            sb_q.delete();
         end else begin
            exp_o = sb_q.pop_front();
            if (sample() !== exp_o) begin
               errors++;
               $display("FAIL decode_%0d got %h expected %h", i, sample(), exp_o);
            end
         end
      end
      @(negedge clk);
      checks++;
      if ({Out_Valid, Reg_Write, Mem_Read, Mem_Write, Branch, Jump, Illegal} !== 7'b0) begin
         errors++;
         $display("FAIL drain_ctrl got %b expected 0000000",
                  {Out_Valid, Reg_Write, Mem_Read, Mem_Write, Branch, Jump, Illegal});
      end
   endtask

   task automatic test_back_to_back();
      obs_t exp_o;
      int   k;
      @(negedge clk);
      Out_Ready = 1'b1; In_Valid = 1'b1;
      k = NVEC - 1; Instr = vec_ins[k]; PC = vec_exp[k].pc;
      sb_q.push_back(vec_exp[k]);
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         checks++;
         if (!Out_Valid || !In_Ready || sb_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_%0d valid=%b in_ready=%b expected 1 1", n, Out_Valid, In_Ready);
            sb_q.delete();
         end else begin
            exp_o = sb_q.pop_front();
            if (sample() !== exp_o) begin
               errors++;
               $display("FAIL b2b_%0d got %h expected %h", n, sample(), exp_o);
            end
         end
         if (n < 6) begin
            k = NVEC - 1 - n; Instr = vec_ins[k]; PC = vec_exp[k].pc;
            sb_q.push_back(vec_exp[k]);
         end else begin
            In_Valid = 1'b0;
         end
      end
   endtask

   task automatic test_stall_flush();
      @(negedge clk);
      In_Valid = 1'b1; Instr = vec_ins[0]; PC = vec_exp[0].pc; Out_Ready = 1'b0;
      @(negedge clk);
      Instr = vec_ins[1]; PC = vec_exp[1].pc;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (In_Ready !== 1'b0 || sample() !== vec_exp[0]) begin
            errors++;
            $display("FAIL stall_%0d in_ready=%b got %h expected 0 %h", c, In_Ready, sample(), vec_exp[0]);
         end
         @(negedge clk);
      end
      Flush = 1'b1;
      checks++;
      if (In_Ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_in_ready got %b expected 0", In_Ready);
      end
      @(negedge clk);
      Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
      checks++;
      if ({Out_Valid, Reg_Write, Branch, Jump} !== 4'b0) begin
         errors++;
         $display("FAIL flush_held got %b expected 0000", {Out_Valid, Reg_Write, Branch, Jump});
      end
      @(negedge clk);
      checks++;
      if (Out_Valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_dropped got %b expected 0", Out_Valid);
      end
      // Flush racing an accept into an empty stage.
      In_Valid = 1'b1; Instr = vec_ins[2]; PC = vec_exp[2].pc; Flush = 1'b1;
      @(negedge clk);
      Flush = 1'b0; In_Valid = 1'b0;
      checks++;
      if (Out_Valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_accept got %b expected 0", Out_Valid);
      end
   endtask

   task automatic test_reset_stall();
      @(negedge clk);
      In_Valid = 1'b1; Instr = vec_ins[5]; PC = vec_exp[5].pc; Out_Ready = 1'b0;
      @(negedge clk);
      rst = 1'b1; Flush = 1'b1;
      @(negedge clk);
      rst = 1'b0; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
      checks++;
      if (Out_Valid !== 1'b0 || Mem_Read !== 1'b0 || PC_Out !== 32'h0) begin
         errors++;
         $display("FAIL reset_stall valid=%b mem_read=%b pc=%h expected 0 0 00000000",
                  Out_Valid, Mem_Read, PC_Out);
      end
   endtask

   task automatic test_illegal();
      logic [31:0] bad_words[3];
      bad_words[0] = 32'h0000057F; // opcode 0x7F
      bad_words[1] = 32'h02208133; // OP with funct7=0000001
      bad_words[2] = 32'h00002063; // BRANCH with funct3=2
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         In_Valid = 1'b1; Instr = bad_words[i]; PC = 32'h300; Out_Ready = 1'b1;
         @(negedge clk);
         In_Valid = 1'b0;
         checks++;
         if ({Out_Valid, Illegal, ALU_Ctrl, Reg_Write, Mem_Read, Mem_Write, Branch, Jump}
             !== {1'b1, ILL_EXP, 5'd0, 5'b0}) begin
            errors++;
            $display("FAIL illegal_%0d got v=%b ill=%b ctrl=%0d ctl=%b expected 1 %b 0 00000", i,
                     Out_Valid, Illegal, ALU_Ctrl, {Reg_Write, Mem_Read, Mem_Write, Branch, Jump}, ILL_EXP);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      load_vectors();
      test_reset();
      test_decode();
      test_back_to_back();
      test_stall_flush();
      test_reset_stall();
      test_illegal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
